multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port instr, input, 32: IR contents; the datapath holds it stable from DECODE to instruction end.
REQ-004 SHALL have port zero, input, 1: ALU equality flag, sampled in EXEC for beq.
REQ-005 SHALL have port mem_ready, input, 1: data-memory completion handshake.
REQ-006 SHALL have output strobes, 1 bit each: ir_write, pc_write, reg_write, mem_read, mem_write, retire, illegal.
REQ-007 SHALL have static control outputs: reg_dst, extop, alu_src, mem_to_reg, jal_sel, lb_sel, sb_sel (1 each); alu_control (3); npc_op (3).
REQ-008 SHALL have output state, 3 bits: current FSM state, for debug.

Function
REQ-009 SHALL implement FSM states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
REQ-010 SHALL transition IDLE->FETCH unconditionally and FETCH->DECODE unconditionally.
REQ-011 SHALL assert ir_write only in FETCH.
REQ-012 SHALL sequence add (funct 100000), sub (100010), ori, and lui as DECODE->EXEC->WB->FETCH.
REQ-013 SHALL sequence lw and lb as DECODE->EXEC->MEM->WB->FETCH.
REQ-014 SHALL sequence sw and sb as DECODE->EXEC->MEM->FETCH.
REQ-015 SHALL sequence beq as DECODE->EXEC->FETCH.
REQ-016 SHALL sequence jr as DECODE->FETCH, and jal as DECODE->WB->FETCH.
REQ-017 SHALL treat any other opcode/funct as illegal: DECODE->FETCH, illegal=1 in DECODE, no register or memory write.
REQ-018 SHALL assert pc_write and retire for exactly one cycle, in the final state of every instruction (illegal included).
REQ-019 SHALL set npc_op at that final state as: 0=PC+4 (default and illegal), 1=beq (NPC uses zero), 2=jal, 3=jr.
REQ-020 SHALL assert reg_write only in WB.
REQ-021 SHALL in MEM hold mem_read (loads) or mem_write (stores) high every cycle until leaving MEM.
REQ-022 SHALL drive static controls from DECODE through the final state, with values: add {reg_dst=1, alu_control=2}; sub {reg_dst=1, alu_control=3}; ori {alu_src=1, alu_control=0}; lui {alu_src=1, alu_control=1}; lw/lb {extop=1, alu_src=1, alu_control=2, mem_to_reg=1, lb_sel for lb}; sw/sb {extop=1, alu_src=1, alu_control=2, sb_sel for sb}; beq {extop=1, alu_control=3}; jal {jal_sel=1}.
REQ-023 SHALL drive all static controls 0 in IDLE and FETCH, and drive every control not listed for an instruction as 0.
REQ-024 SHALL never assert mem_read and mem_write in the same cycle, nor reg_write together with mem_write.

Reset
REQ-025 SHALL on rst_n low force state to IDLE immediately, without waiting for clk.
REQ-026 SHALL hold every output at 0 while in reset, including mid-MEM, where mem_write/mem_read drop asynchronously.
REQ-027 SHALL after rst_n rises spend exactly one cycle in IDLE (all outputs 0) and then enter FETCH.

Configuration
REQ-028 SHALL, with MULTICYCLE_MEM_WAIT_EN defined, leave MEM on the first rising edge where mem_ready=1, so MEM lasts 1 + the number of wait cycles.
REQ-029 SHALL, without MULTICYCLE_MEM_WAIT_EN, make MEM exactly one cycle and ignore mem_ready.

Structure
REQ-030 SHALL place state encodings, opcode/funct constants, alu_control codes, and npc_op codes in shared package mips_pkg.
REQ-031 SHALL use one combinational sub-module, main_decoder (instr -> instruction class + static controls); the FSM and strobe gating SHALL be in multicycle_ctrl.

Verification
REQ-032 SHALL cover add: instr=0x00221820 -> FETCH, DECODE, EXEC, WB; reg_write=1, reg_dst=1, alu_control=2 in WB; pc_write=1, npc_op=0, retire=1 in WB only.
REQ-033 SHALL cover load wait: with MULTICYCLE_MEM_WAIT_EN, lw 0x8C430004 and mem_ready low for 3 cycles -> mem_read high 4 cycles, then WB with mem_to_reg=1; 8 cycles FETCH to FETCH.
REQ-034 SHALL cover branches and jumps: beq 0x10220003 -> 3 cycles, EXEC with alu_control=3, pc_write=1, npc_op=1; jr 0x03E00008 -> 2 cycles, npc_op=3 in DECODE.
REQ-035 SHALL cover jal: 0x0C000010 -> DECODE then WB with reg_write=1, jal_sel=1, npc_op=2, pc_write=1.
REQ-036 SHALL cover reset mid-operation: rst_n low in MEM of sb 0xA0430001 -> mem_write and sb_sel fall in the same cycle, state=0; after release, one IDLE cycle then FETCH.
REQ-037 SHALL cover illegal opcode: 0xFC000000 -> illegal=1 in DECODE, pc_write with npc_op=0, no reg_write or mem_write; next state FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encoding,
// opcode/funct constants, ALU and next-PC operation codes, instruction
// classes and the static control bundle produced by the main decoder.
package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_OR   = 3'd0;
    localparam logic [2:0] ALU_LUI  = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;

    localparam logic [2:0] NPC_PC4  = 3'd0;
    localparam logic [2:0] NPC_BEQ  = 3'd1;
    localparam logic [2:0] NPC_JAL  = 3'd2;
    localparam logic [2:0] NPC_JR   = 3'd3;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_JR,
        CLS_JAL,
        CLS_ILLEGAL
    } instr_class_t;

    typedef struct packed {
        logic       reg_dst;
        logic       extop;
        logic       alu_src;
        logic       mem_to_reg;
        logic       jal_sel;
        logic       lb_sel;
        logic       sb_sel;
        logic [2:0] alu_control;
    } static_ctrl_t;

    localparam static_ctrl_t CTRL_NONE = '0;

    // Next-PC selection used on the final cycle of an instruction.
    function automatic logic [2:0] npc_for_class(instr_class_t cls);
        case (cls)
            CLS_BEQ: return NPC_BEQ;
            CLS_JAL: return NPC_JAL;
            CLS_JR:  return NPC_JR;
            default: return NPC_PC4;
        endcase
    endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational main decoder: classifies the instruction word and produces
// the static datapath controls. Unknown opcodes/functs decode as illegal
// with every static control at 0.
module main_decoder
    import mips_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t instr_class,
    output static_ctrl_t ctrl
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    // Opcode/funct lookup into instruction class and static controls.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        ctrl        = CTRL_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        instr_class      = CLS_ALU;
                        ctrl.reg_dst     = 1'b1;
                        ctrl.alu_control = ALU_ADD;
                    end
                    FN_SUB: begin
                        instr_class      = CLS_ALU;
                        ctrl.reg_dst     = 1'b1;
                        ctrl.alu_control = ALU_SUB;
                    end
                    FN_JR: begin
                        instr_class = CLS_JR;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                instr_class      = CLS_ALU;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_OR;
            end
            OP_LUI: begin
                instr_class      = CLS_ALU;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_LUI;
            end
            OP_LW, OP_LB: begin
                instr_class      = CLS_LOAD;
                ctrl.extop       = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.lb_sel      = (opcode == OP_LB);
            end
            OP_SW, OP_SB: begin
                instr_class      = CLS_STORE;
                ctrl.extop       = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
                ctrl.sb_sel      = (opcode == OP_SB);
            end
            OP_BEQ: begin
                instr_class      = CLS_BEQ;
                ctrl.extop       = 1'b1;
                ctrl.alu_control = ALU_SUB;
            end
            OP_JAL: begin
                instr_class  = CLS_JAL;
                ctrl.jal_sel = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: FSM sequencing (IDLE/FETCH/DECODE/EXEC/MEM/WB)
// and per-state strobe gating around the combinational main_decoder.
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN -- when defined, MEM is held
// until mem_ready is seen high; otherwise MEM lasts one cycle.
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        retire,
    output logic        illegal,
    output logic        reg_dst,
    output logic        extop,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        jal_sel,
    output logic        lb_sel,
    output logic        sb_sel,
    output logic [2:0]  alu_control,
    output logic [2:0]  npc_op,
    output logic [2:0]  state
);

    state_t       state_reg;
    state_t       state_next;
    instr_class_t instr_class;
    static_ctrl_t dec_ctrl;
    static_ctrl_t static_ctrl;
    logic         mem_done;
    logic         last_cycle;
    logic         unused_zero;

    // The branch outcome is resolved in the NPC unit; the controller only
    // selects the branch path, so zero is not consumed here.
    assign unused_zero = zero;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    main_decoder u_main_decoder (
        .instr       (instr),
        .instr_class (instr_class),
        .ctrl        (dec_ctrl)
    );

    assign state = state_reg;

    // State register; reset drops straight to IDLE without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection by instruction class.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (instr_class)
                    CLS_JR, CLS_ILLEGAL: state_next = S_FETCH;
                    CLS_JAL:             state_next = S_WB;
                    default:             state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (instr_class)
                    CLS_ALU:              state_next = S_WB;
                    CLS_LOAD, CLS_STORE:  state_next = S_MEM;
                    default:              state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_done) begin
                    state_next = (instr_class == CLS_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // Strobe gating and static-control qualification per state.
    always_comb begin
        last_cycle = 1'b0;
        case (state_reg)
            S_DECODE: last_cycle = (instr_class == CLS_JR) || (instr_class == CLS_ILLEGAL);
            S_EXEC:   last_cycle = (instr_class == CLS_BEQ);
            S_MEM:    last_cycle = (instr_class == CLS_STORE) && mem_done;
            S_WB:     last_cycle = 1'b1;
            default:  last_cycle = 1'b0;
        endcase

        static_ctrl = CTRL_NONE;
        if (state_reg inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            static_ctrl = dec_ctrl;
        end

        ir_write    = (state_reg == S_FETCH);
        pc_write    = last_cycle;
        retire      = last_cycle;
        npc_op      = last_cycle ? npc_for_class(instr_class) : NPC_PC4;
        reg_write   = (state_reg == S_WB);
        mem_read    = (state_reg == S_MEM) && (instr_class == CLS_LOAD);
        mem_write   = (state_reg == S_MEM) && (instr_class == CLS_STORE);
        illegal     = (state_reg == S_DECODE) && (instr_class == CLS_ILLEGAL);

        reg_dst     = static_ctrl.reg_dst;
        extop       = static_ctrl.extop;
        alu_src     = static_ctrl.alu_src;
        mem_to_reg  = static_ctrl.mem_to_reg;
        jal_sel     = static_ctrl.jal_sel;
        lb_sel      = static_ctrl.lb_sel;
        sb_sel      = static_ctrl.sb_sel;
        alu_control = static_ctrl.alu_control;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction model expands
// each instruction into its expected state path and per-cycle outputs, a
// compare process checks every cycle, and literal checks pin key cycles.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_write, pc_write, reg_write, mem_read, mem_write, retire, illegal;
    logic        reg_dst, extop, alu_src, mem_to_reg, jal_sel, lb_sel, sb_sel;
    logic [2:0]  alu_control, npc_op, state;

`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .retire(retire), .illegal(illegal),
        .reg_dst(reg_dst), .extop(extop), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .jal_sel(jal_sel), .lb_sel(lb_sel), .sb_sel(sb_sel),
        .alu_control(alu_control), .npc_op(npc_op), .state(state)
    );

    always #5 clk = ~clk;

    // Packed view: [22:20] state, 19 ir_write, 18 pc_write, 17 reg_write,
    // 16 mem_read, 15 mem_write, 14 retire, 13 illegal, 12 reg_dst, 11 extop,
    // 10 alu_src, 9 mem_to_reg, 8 jal_sel, 7 lb_sel, 6 sb_sel, [5:3] alu, [2:0] npc
    logic [22:0] act;
    assign act = {state, ir_write, pc_write, reg_write, mem_read, mem_write, retire, illegal,
                  reg_dst, extop, alu_src, mem_to_reg, jal_sel, lb_sel, sb_sel,
                  alu_control, npc_op};

    int          checks = 0;
    int          errors = 0;
    logic [22:0] exp_q[$];
    logic [22:0] cap, cap_pre, cap_first;
    int          ncyc;

    // Per-cycle comparison against the model's expectation queue.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [22:0] e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle t=%0t actual=%h required=%h", $time, act, e);
            end else begin
                $display("ok   cycle t=%0t state=%0d outputs=%h", $time, act[22:20], act);
            end
        end
    end

    task automatic chk(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end else begin
            $display("ok   %s = %0d", name, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its state path and drive/expect each cycle.
    // stop_at >= 0 truncates the run after that many cycles.
    task automatic run_instr(input logic [31:0] ins, input int waits, input logic z,
                             input int stop_at);
        logic [2:0]  path[$];
        logic [5:0]  op, fn;
        logic [9:0]  stat;
        logic [2:0]  npc;
        logic [2:0]  st;
        logic        last;
        logic [22:0] e;
        int          kind;   // 0 alu, 1 load, 2 store, 3 beq, 4 jr, 5 jal, 6 illegal
        int          w, m, n;
        op   = ins[31:26];
        fn   = ins[5:0];
        stat = 10'd0;
        npc  = 3'd0;
        kind = 6;
        w    = WAIT_EN ? waits : 0;
        case (op)
            6'h00: begin
                if (fn == 6'h20) begin kind = 0; stat = 10'b1000000_010; end
                else if (fn == 6'h22) begin kind = 0; stat = 10'b1000000_011; end
                else if (fn == 6'h08) begin kind = 4; npc = 3'd3; end
            end
            6'h0D: begin kind = 0; stat = 10'b0010000_000; end
            6'h0F: begin kind = 0; stat = 10'b0010000_001; end
            6'h23: begin kind = 1; stat = 10'b0111000_010; end
            6'h20: begin kind = 1; stat = 10'b0111010_010; end
            6'h2B: begin kind = 2; stat = 10'b0110000_010; end
            6'h28: begin kind = 2; stat = 10'b0110001_010; end
            6'h04: begin kind = 3; stat = 10'b0100000_011; npc = 3'd1; end
            6'h03: begin kind = 5; stat = 10'b0000100_000; npc = 3'd2; end
            default: ;
        endcase
        path.push_back(3'd1);
        path.push_back(3'd2);
        case (kind)
            0: begin path.push_back(3'd3); path.push_back(3'd5); end
            1: begin
                path.push_back(3'd3);
                for (int k = 0; k <= w; k++) path.push_back(3'd4);
                path.push_back(3'd5);
            end
            2: begin
                path.push_back(3'd3);
                for (int k = 0; k <= w; k++) path.push_back(3'd4);
            end
            3: path.push_back(3'd3);
            5: path.push_back(3'd5);
            default: ;
        endcase
        n    = path.size();
        ncyc = n;
        m    = 0;
        for (int i = 0; i < n; i++) begin
            if (stop_at >= 0 && i >= stop_at) break;
            tick();
            st   = path[i];
            last = (i == n - 1);
            if (i == 0) instr = ins;
            zero      = z;
            mem_ready = WAIT_EN && (st == 3'd4) && (m == w);
            if (st == 3'd4) m++;
            e = {st, (st == 3'd1), last, (st == 3'd5), (st == 3'd4 && kind == 1),
                 (st == 3'd4 && kind == 2), last, (st == 3'd2 && kind == 6),
                 (st == 3'd1) ? 10'd0 : stat, last ? npc : 3'd0};
            exp_q.push_back(e);
            #1;
            if (i == 0) cap_first = act;
            if (i == n - 2) cap_pre = act;
            if (i == n - 1) cap = act;
        end
    endtask

    initial begin
        #3;
        chk("reset_all_outputs_zero", int'(act), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(23'd0);    // the single IDLE cycle after release

        // add
        run_instr(32'h00221820, 0, 1'b0, -1);
        chk("add_first_state_fetch", int'(cap_first[22:20]), 1);
        chk("add_cycles", ncyc, 4);
        chk("add_wb_state", int'(cap[22:20]), 5);
        chk("add_wb_reg_write", int'(cap[17]), 1);
        chk("add_wb_reg_dst", int'(cap[12]), 1);
        chk("add_wb_alu_control", int'(cap[5:3]), 2);
        chk("add_wb_pc_write", int'(cap[18]), 1);
        chk("add_wb_npc_op", int'(cap[2:0]), 0);
        chk("add_exec_retire", int'(cap_pre[14]), 0);

        run_instr(32'h00432022, 0, 1'b0, -1);   // sub
        run_instr(32'h34420005, 0, 1'b0, -1);   // ori
        run_instr(32'h3C01ABCD, 0, 1'b0, -1);   // lui

        // lw with three wait cycles (only effective when waits are enabled)
        run_instr(32'h8C430004, 3, 1'b0, -1);
        chk("lw_cycles", ncyc, WAIT_EN ? 8 : 5);
        chk("lw_wb_state", int'(cap[22:20]), 5);
        chk("lw_wb_mem_to_reg", int'(cap[9]), 1);
        chk("lw_last_mem_read", int'(cap_pre[16]), 1);

        run_instr(32'h80430002, 0, 1'b0, -1);   // lb
        run_instr(32'hAC430008, 1, 1'b0, -1);   // sw

        // beq taken and not taken
        run_instr(32'h10220003, 0, 1'b1, -1);
        chk("beq_cycles", ncyc, 3);
        chk("beq_exec_alu_control", int'(cap[5:3]), 3);
        chk("beq_exec_pc_write", int'(cap[18]), 1);
        chk("beq_exec_npc_op", int'(cap[2:0]), 1);
        run_instr(32'h10220003, 0, 1'b0, -1);

        // jr
        run_instr(32'h03E00008, 0, 1'b0, -1);
        chk("jr_cycles", ncyc, 2);
        chk("jr_decode_state", int'(cap[22:20]), 2);
        chk("jr_decode_npc_op", int'(cap[2:0]), 3);

        // jal
        run_instr(32'h0C000010, 0, 1'b0, -1);
        chk("jal_pre_state_decode", int'(cap_pre[22:20]), 2);
        chk("jal_wb_reg_write", int'(cap[17]), 1);
        chk("jal_wb_jal_sel", int'(cap[8]), 1);
        chk("jal_wb_npc_op", int'(cap[2:0]), 2);
        chk("jal_wb_pc_write", int'(cap[18]), 1);

        // illegal opcode and illegal R-type funct
        run_instr(32'hFC000000, 0, 1'b0, -1);
        chk("ill_decode_illegal", int'(cap[13]), 1);
        chk("ill_decode_pc_write", int'(cap[18]), 1);
        chk("ill_decode_npc_op", int'(cap[2:0]), 0);
        chk("ill_no_reg_write", int'(cap[17]), 0);
        chk("ill_no_mem_write", int'(cap[15]), 0);
        run_instr(32'h00000001, 0, 1'b0, -1);

        // reset in the MEM cycle of sb
        run_instr(32'hA0430001, 2, 1'b0, 3);
        tick();
        mem_ready = 1'b0;
        chk("sb_mem_state", int'(state), 4);
        chk("sb_mem_write_before_reset", int'(mem_write), 1);
        chk("sb_sel_before_reset", int'(sb_sel), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("sb_reset_state", int'(state), 0);
        chk("sb_reset_mem_write", int'(mem_write), 0);
        chk("sb_reset_sb_sel", int'(sb_sel), 0);
        chk("sb_reset_all_outputs", int'(act), 0);
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.push_back(23'd0);
        run_instr(32'hA0430001, 2, 1'b0, -1);
        chk("post_reset_fetch", int'(cap_first[22:20]), 1);

        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
